// File: rtl/ifu_fetch.sv
// Instruction fetch: one imem read per PC, word plus PC handed to decode; IFU_MISALIGN_CHECK_EN faults misaligned PCs.
// Latency: bubble after reset, then REQ -> WAIT (variable) -> HOLD, at most one instruction per 3 cycles.
// Backpressure: request held until imem_req_ready; instruction held in HOLD/FAULT until decode accepts or flush.
module ifu_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_advance,
  input  logic                  flush,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                    drop_q, drop_d;
  logic [INST_WIDTH-1:0]   inst_d;
  logic [ADDR_WIDTH-1:0]   inst_pc_d;
  logic                    inst_fault_d;
  logic                    misalign;
  logic                    timeout;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign = |pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Saturating wait counter; timeout fires on the cycle it would reach MAX_WAIT.
  assign cnt_inc = (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;
  assign timeout = (cnt_inc == CW'(MAX_WAIT));

  assign imem_req_valid = (state_q == S_REQ) & ~misalign;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == S_HOLD) | (state_q == S_FAULT);
  assign pc_advance     = (state_q == S_HOLD) & inst_ready & ~flush;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_fault_d = inst_fault;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misalign) begin
          // No request goes out; a redirect simply re-evaluates the new pc.
          if (!flush) begin
            inst_d       = '0;
            inst_pc_d    = pc;
            inst_fault_d = 1'b1;
            drop_d       = 1'b0;
            state_d      = S_FAULT;
          end
        end else begin
          if (flush) drop_d = 1'b1;
          if (imem_req_ready) begin
            addr_d  = pc;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (imem_rsp_valid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = addr_q;
            inst_fault_d = 1'b0;
            state_d      = S_HOLD;
          end
        end else if (timeout) begin
          // A fetch already redirected away is refetched rather than reported.
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d       = '0;
            inst_pc_d    = addr_q;
            inst_fault_d = 1'b1;
            state_d      = S_FAULT;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush || inst_ready) state_d = S_REQ;
      end
      S_FAULT: begin
        if (flush) begin
          inst_fault_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_fault <= inst_fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder, PC register and decode consumer around the DUT.
// Expected instruction stream is one memory word per architectural PC, discarded on redirect.
module tb_ifu_fetch;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          pc_advance;
  logic          flush;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_fault;

  always #5 clk = ~clk;

  ifu_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
    logic          fault;
  } exp_t;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            accepts = 0;
  int            ready_pct = 100;
  int            accept_pct = 0;
  int            mem_lat = -1;
  bit            mem_silent = 0;
  bit            mem_pending = 0;
  bit            mem_stale = 0;
  int            mem_cnt = 0;
  logic [AW-1:0] mem_addr = '0;
  logic [AW-1:0] last_hs_addr = '0;
  bit            rel_rst = 0;
  bit            req_wait = 0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic expect_fetch(input logic [AW-1:0] a);
    exp_q.push_back(exp_t'{inst: mem_word(a), pc: a, fault: 1'b0});
  endtask

  // One clock of environment: memory, decode, PC register and protocol checks.
  task automatic cycle(input bit fl, input logic [AW-1:0] tgt, output bit hs);
    bit            adv_exp;
    bit            adv_act;
    logic [AW-1:0] hs_addr;
    @(negedge clk);
    if (rel_rst) rst = 1'b1;
    if (mem_pending && !mem_silent && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_stale ? 32'hDEAD_BEEF : mem_word(mem_addr);
      mem_pending    = 0;
      mem_stale      = 0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_pending && mem_cnt > 0) mem_cnt--;
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    inst_ready     = ($urandom_range(99) < accept_pct);
    flush          = fl;
    if (fl) begin
      pc = tgt;
      exp_q.delete();
      expect_fetch(tgt);
    end
    #1;
    if (rel_rst) begin
      check("bubble_no_req", imem_req_valid, 0);
      rel_rst = 0;
    end
    adv_exp = inst_valid && inst_ready && !flush && exp_q.size() > 0 && !exp_q[0].fault;
    adv_act = pc_advance;
    check("pc_advance", adv_act, adv_exp);
    if (inst_valid) check("no_req_while_presenting", imem_req_valid, 0);
    if (req_wait) check("req_held", imem_req_valid, 1);
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    if (hs) check("req_addr", hs_addr, pc);
    req_wait = imem_req_valid && !imem_req_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      check("single_outstanding", mem_pending, 0);
      mem_pending  = 1;
      mem_addr     = hs_addr;
      last_hs_addr = hs_addr;
      mem_cnt      = (mem_lat < 0) ? int'($urandom_range(2)) : mem_lat;
    end
    if (adv_act) begin
      pc = pc + 32'd4;
      expect_fetch(pc);
    end
  endtask

  task automatic run_until_valid(input int bound, input string name);
    bit hs;
    int n = 0;
    while (!inst_valid && n < bound) begin
      cycle(1'b0, '0, hs);
      n++;
    end
    check(name, inst_valid, 1);
  endtask

  task automatic run_until_hs(input int bound, input string name);
    bit hs = 0;
    int n = 0;
    while (!hs && n < bound) begin
      cycle(1'b0, '0, hs);
      n++;
    end
    check(name, hs, 1);
  endtask

  // Scoreboard monitor: pops one expectation per instruction decode takes.
  initial begin : monitor
    logic [IW-1:0] prev_inst;
    logic [AW-1:0] prev_pc;
    bit            prev_stall;
    bit            fault_taken;
    exp_t          e;
    prev_inst   = '0;
    prev_pc     = '0;
    prev_stall  = 0;
    fault_taken = 0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_stall && inst_valid) begin
        check("stable_inst", inst, prev_inst);
        check("stable_inst_pc", inst_pc, prev_pc);
      end
      if (rst && inst_valid && inst_ready && !flush && !(inst_fault && fault_taken)) begin
        accepts++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got %0h at %0h with nothing expected", inst, inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst", inst, e.inst);
          check("inst_pc", inst_pc, e.pc);
          check("inst_fault", inst_fault, e.fault);
        end
        fault_taken = inst_fault;
      end
      if (!inst_valid) fault_taken = 0;
      prev_stall = rst && inst_valid && !inst_ready && !flush;
      prev_inst  = inst;
      prev_pc    = inst_pc;
    end
  end

  initial begin : stim
    bit hs;
    int w;
    rst            = 1'b1;
    pc             = 32'h8000_0000;
    flush          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_inst_valid", inst_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_fault", inst_fault, 0);
    check("rst_pc_advance", pc_advance, 0);

    // Basic fetch with a two-cycle response, then backpressure.
    expect_fetch(pc);
    mem_lat = 1;
    rel_rst = 1;
    run_until_valid(20, "basic_valid");
    check("basic_inst", inst, 32'h0010_0093);
    check("basic_inst_pc", inst_pc, 32'h8000_0000);
    repeat (5) cycle(1'b0, '0, hs);
    check("bp_still_valid", inst_valid, 1);
    accept_pct = 100;
    cycle(1'b0, '0, hs);
    accept_pct = 0;
    check("pc_stepped", pc, 32'h8000_0004);
    check("valid_dropped", inst_valid, 0);

    // Flush one cycle after the handshake; the late response is stale.
    mem_lat = 2;
    run_until_hs(10, "next_req");
    check("next_req_addr", last_hs_addr, 32'h8000_0004);
    mem_stale = 1;
    mem_lat   = -1;
    cycle(1'b1, 32'h8000_0100, hs);
    run_until_hs(20, "redirect_req");
    check("redirect_req_addr", last_hs_addr, 32'h8000_0100);
    run_until_valid(20, "redirect_valid");
    check("redirect_inst_pc", inst_pc, 32'h8000_0100);

    // Flush and accept in the same HOLD cycle.
    accept_pct = 100;
    cycle(1'b1, 32'h8000_0200, hs);
    accept_pct = 0;
    check("flush_accept_valid", inst_valid, 0);
    run_until_hs(10, "flush_accept_req");
    check("flush_accept_addr", last_hs_addr, 32'h8000_0200);
    run_until_valid(20, "flush_accept_valid2");

    // Timeout: memory never answers the next fetch.
    mem_silent = 1;
    accept_pct = 100;
    cycle(1'b0, '0, hs);
    accept_pct = 0;
    exp_q.delete();
    exp_q.push_back(exp_t'{inst: '0, pc: pc, fault: 1'b1});
    run_until_hs(10, "timeout_req");
    w = 0;
    while (!inst_valid && w < 20) begin
      cycle(1'b0, '0, hs);
      w++;
    end
    check("timeout_cycles", w, MW);
    check("timeout_fault", inst_fault, 1);
    check("timeout_inst", inst, 0);
    check("timeout_inst_pc", inst_pc, 32'h8000_0204);
    accept_pct = 100;
    repeat (3) cycle(1'b0, '0, hs);
    accept_pct = 0;
    check("fault_stays", inst_valid, 1);
    check("fault_no_step", pc, 32'h8000_0204);
    mem_silent  = 0;
    mem_pending = 0;
    cycle(1'b1, 32'h8000_0300, hs);
    check("fault_exit", inst_valid, 0);
    run_until_valid(20, "after_fault_valid");

    // Asynchronous reset while waiting; its response arrives after release.
    accept_pct = 100;
    cycle(1'b0, '0, hs);
    accept_pct = 0;
    mem_lat = 3;
    run_until_hs(10, "pre_reset_req");
    mem_stale = 1;
    #2 rst = 1'b0;
    #1;
    check("arst_req_valid", imem_req_valid, 0);
    check("arst_inst_valid", inst_valid, 0);
    check("arst_inst", inst, 0);
    check("arst_inst_pc", inst_pc, 0);
    check("arst_fault", inst_fault, 0);
    exp_q.delete();
    expect_fetch(pc);
    req_wait  = 0;
    ready_pct = 0;
    cycle(1'b0, '0, hs);
    rel_rst = 1;
    cycle(1'b0, '0, hs);
    check("req_after_bubble", imem_req_valid, 1);
    repeat (3) cycle(1'b0, '0, hs);
    check("stale_rsp_ignored", inst_valid, 0);
    ready_pct = 100;
    mem_lat   = -1;
    run_until_valid(20, "reset_refetch");
    check("reset_refetch_pc", inst_pc, pc);

    // Random traffic with occasional redirects.
    ready_pct  = 70;
    accept_pct = 60;
    for (int i = 0; i < 800; i++) begin
      logic [AW-1:0] tgt;
      tgt = $urandom & 32'hFFFF_FFFC;
      cycle($urandom_range(99) < 4, tgt, hs);
    end
    check("progress", accepts > 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
